bcd_to_ex3_serial: RTL and testbench
====================================

Name: bcd_to_ex3_serial

Overview:
- Bit-serial BCD-to-Excess-3 encoder; the transmit-side counterpart of the team's Excess-3-to-BCD decode path.
- Accepts words of DIGITS packed BCD digits, LSB-first: least significant bit of each digit first, least significant digit first.
- Emits the Excess-3 stream (each digit + 4'b0011), one bit per accepted bit, with one cycle of latency.
- Flags non-BCD digits (1010..1111) per word. Sits between a serial BCD source and an Excess-3 serial link.

Parameters:
DIGITS, 4, number of BCD digits per word (>=1); word length = 4*DIGITS bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_bit/in_first valid this cycle; low = stall
in_bit  input  1  serial BCD data bit
in_first  input  1  with in_valid: this bit is bit 0 of digit 0 of a new word
out_valid  output  1  out_bit valid (registered)
out_bit  output  1  serial Excess-3 data bit
out_last  output  1  with out_valid: last bit of the word
out_err  output  1  with out_last: at least one digit of the word was > 9

Behaviour:
- One clock, synchronous active-high reset. All outputs registered.
- Reset values: out_valid=0, out_bit=0, out_last=0, out_err=0. Internal state on reset: bit position=0, digit index=0, carry=0, error accumulator=0.
- Reset asserted mid-word discards the partial word. No out_last is produced for it. The next accepted bit is bit 0 of digit 0, whether or not in_first is asserted.
- Latency: a bit accepted at edge N (in_valid=1) drives out_valid=1 and the corresponding out_bit from edge N until edge N+1.
- Stall: in_valid=0 leaves position, carry and accumulator unchanged and gives out_valid=0 next cycle. Gaps of any length are legal.
- Serial add per digit, with constant k(pos)=1,1,0,0 for bit positions 0..3:
  - out_bit = in_bit ^ k ^ carry
  - carry_next = majority(in_bit, k, carry)
  - carry is cleared at bit 0 of every digit, and the carry out of bit 3 is discarded.
- Result is computed mod 16 for every digit, including invalid ones: 1010->1101, 1011->1110, 1100->1111, 1101->0000, 1110->0001, 1111->0010.
- Invalid detect:
  - Bits 1 and 2 of the current digit are held.
  - At bit 3: digit_bad = in_bit & (b1 | b2).
  - The error accumulator ORs digit_bad across the word.
  - out_err = accumulator | digit_bad of the final digit, presented with out_last.
  - out_err=0 whenever out_last=0.
- Counters:
  - Bit position is 2 bits and wraps 3->0, then increments the digit index.
  - Digit index is clog2(DIGITS) bits, minimum 1 bit. It wraps DIGITS-1 -> 0 after the last bit.
  - out_last asserts for the output of bit 3 of digit DIGITS-1.
  - After wrap, the accumulator clears and a new word starts automatically; in_first is optional on aligned words.
- in_first with in_valid:
  - Forces this bit to be bit 0 of digit 0, with carry=0 and accumulator=0, regardless of current position.
  - If it arrives mid-word, the partial word is aborted: its bits already emitted stand, but no out_last or out_err is produced for it.
  - in_first with in_valid=0 is ignored.
- Simultaneous last-bit acceptance and new in_first on the next cycle: no bubble required; back-to-back words at full rate.

Decomposition:
- Shared package ex3_pkg holds:
  - EX3_OFFSET = 4'b0011
  - BCD_DIGIT_W = 4
  - BCD_MAX = 4'd9
  - function for Excess-3 constant bit by position
  - This package is shared with the Excess-3-to-BCD decode path.
- One natural sub-module, ex3_bit_slice: combinational full-adder slice (in_bit, k, carry -> sum, carry_next).
- Top contains the position/digit counters, the b1/b2 hold regs, the error accumulator and the output registers.

Test Plan:
- Reset, then DIGITS=1, digit 5 sent as bits 1,0,1,0 with in_first on the first bit -> out_bit 0,0,0,1 (1000 = 8); out_last on the 4th output; out_err=0.
- DIGITS=4, word digits (LSB-first) 9,5,2,0, i.e. value 0259, streamed continuously -> Excess-3 digits C,8,5,3, bit stream 0,0,1,1, 0,0,0,1, 1,0,1,0, 1,1,0,0; single out_last on bit 16; out_err=0.
- Same word with in_valid low for 3 cycles after bits 2, 7 and 15 -> identical output sequence; out_valid=0 during the gaps; no extra out_last.
- DIGITS=4, digit 1 = 1011, others 0 -> that digit outputs 1110, others 0011; out_err=1 with out_last only. The next clean word gives out_err=0.
- in_first reasserted at bit 6 of a word, then a full clean word follows -> no out_last for the aborted word; the new word is encoded correctly with out_last on its 16th bit.
- rst pulsed after bit 9, then a word sent without in_first -> all outputs 0 during reset; the word is encoded from digit 0, bit 0 with correct carry; out_last on its 16th bit.

Source files
------------

// File: rtl/ex3_pkg.sv
// Excess-3 constants shared by the BCD-to-Excess-3 encode path and the
// Excess-3-to-BCD decode path.
package ex3_pkg;

  localparam logic [3:0] EX3_OFFSET  = 4'b0011;
  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;

  // Bit of the Excess-3 offset that is added at a given bit position of a digit
  function automatic logic ex3_k_bit(input logic [1:0] pos);
    return EX3_OFFSET[pos];
  endfunction

endpackage

// File: rtl/ex3_bit_slice.sv
// One-bit full-adder slice used for the serial digit + offset addition.
module ex3_bit_slice (
  input  logic in_bit,
  input  logic k,
  input  logic carry,
  output logic sum,
  output logic carry_next
);

  assign sum        = in_bit ^ k ^ carry;
  assign carry_next = (in_bit & k) | (in_bit & carry) | (k & carry);

endmodule

// File: rtl/bcd_to_ex3_serial.sv
// Bit-serial BCD to Excess-3 encoder. Digits arrive LSB-first, least
// significant digit first; each digit has 0011 added mod 16 through a
// single full-adder slice, and non-BCD digits are flagged per word.
module bcd_to_ex3_serial
  import ex3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_first,
  output logic out_valid,
  output logic out_bit,
  output logic out_last,
  output logic out_err
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);

  logic [1:0]    pos;
  logic [DW-1:0] digit;
  logic          carry;
  logic          b1;
  logic          b2;
  logic          acc;

  logic [1:0]    pos_eff;
  logic [DW-1:0] digit_eff;
  logic          carry_in;
  logic          acc_eff;
  logic          k;
  logic          sum;
  logic          carry_out;
  logic          digit_bad;
  logic          is_last;

  ex3_bit_slice u_slice (
    .in_bit     (in_bit),
    .k          (k),
    .carry      (carry_in),
    .sum        (sum),
    .carry_next (carry_out)
  );

  // Resolve where this bit lands: in_first restarts the word at bit 0 of digit 0
  always_comb begin
    pos_eff   = pos;
    digit_eff = digit;
    acc_eff   = acc;
    if (in_first) begin
      pos_eff   = 2'd0;
      digit_eff = '0;
      acc_eff   = 1'b0;
    end
    carry_in  = (pos_eff == 2'd0) ? 1'b0 : carry;
    k         = ex3_k_bit(pos_eff);
    digit_bad = (pos_eff == 2'd3) & in_bit & (b1 | b2);
    is_last   = (pos_eff == 2'd3) && (digit_eff == LAST_DIGIT);
  end

  // Advance counters, hold bits 1/2, accumulate errors and register outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pos       <= 2'd0;
      digit     <= '0;
      carry     <= 1'b0;
      b1        <= 1'b0;
      b2        <= 1'b0;
      acc       <= 1'b0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_bit   <= sum;
      out_last  <= is_last;
      out_err   <= is_last & (acc_eff | digit_bad);
      pos       <= pos_eff + 2'd1;
      carry     <= carry_out;
      if (pos_eff == 2'd1) b1 <= in_bit;
      if (pos_eff == 2'd2) b2 <= in_bit;
      if (pos_eff == 2'd3) begin
        if (is_last) begin
          digit <= '0;
          acc   <= 1'b0;
        end else begin
          digit <= digit_eff + DW'(1);
          acc   <= acc_eff | digit_bad;
        end
      end else begin
        digit <= digit_eff;
        acc   <= acc_eff;
      end
    end else begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_to_ex3_serial.sv
// Directed bench for bcd_to_ex3_serial with one-digit and four-digit instances.
module tb_bcd_to_ex3_serial;

  logic clk = 1'b0;
  logic rst;
  logic v1, b1, f1;
  logic ov1, ob1, ol1, oe1;
  logic v4, b4, f4;
  logic ov4, ob4, ol4, oe4;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  bcd_to_ex3_serial #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_bit(b1), .in_first(f1),
    .out_valid(ov1), .out_bit(ob1), .out_last(ol1), .out_err(oe1)
  );

  bcd_to_ex3_serial #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_bit(b4), .in_first(f4),
    .out_valid(ov4), .out_bit(ob4), .out_last(ol4), .out_err(oe4)
  );

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v1 = 1'b1; b1 = 1'b1; f1 = 1'b0;
    v4 = 1'b1; b4 = 1'b1; f4 = 1'b0;
    step();
    step();
    checks++;
    if ({ov1, ob1, ol1, oe1} !== 4'b0000)
      $display("[TB] FAIL reset_dut1 got=%b want=0000", {ov1, ob1, ol1, oe1});
    else passes++;
    checks++;
    if ({ov4, ob4, ol4, oe4} !== 4'b0000)
      $display("[TB] FAIL reset_dut4 got=%b want=0000", {ov4, ob4, ol4, oe4});
    else passes++;
    rst = 1'b0; v1 = 1'b0; b1 = 1'b0; v4 = 1'b0; b4 = 1'b0;
    step();
  endtask

  // Single-digit words: 5 -> 8 clean, then C -> F flagged, back to back
  task automatic test_single_digit();
    logic [7:0] in_w;
    logic [7:0] exp_w;
    in_w  = 8'hC5;
    exp_w = 8'hF8;
    for (int i = 0; i < 8; i++) begin
      v1 = 1'b1; b1 = in_w[i]; f1 = (i == 0);
      step();
      checks++;
      if ({ov1, ob1, ol1, oe1} !== {1'b1, exp_w[i], (i % 4) == 3, i == 7})
        $display("[TB] FAIL digit1_bit%0d got=%b want=%b", i, {ov1, ob1, ol1, oe1},
                 {1'b1, exp_w[i], (i % 4) == 3, i == 7});
      else passes++;
    end
    v1 = 1'b0; f1 = 1'b0;
    step();
  endtask

  // Word 0259 streamed continuously, then FEDA back to back with in_first
  task automatic test_back_to_back();
    logic [31:0] in_w;
    logic [31:0] exp_w;
    in_w  = 32'hFEDA_0259;
    exp_w = 32'h210D_358C;
    for (int i = 0; i < 32; i++) begin
      v4 = 1'b1; b4 = in_w[i]; f4 = (i == 0) || (i == 16);
      step();
      checks++;
      if ({ov4, ob4, ol4, oe4} !== {1'b1, exp_w[i], (i % 16) == 15, i == 31})
        $display("[TB] FAIL b2b_bit%0d got=%b want=%b", i, {ov4, ob4, ol4, oe4},
                 {1'b1, exp_w[i], (i % 16) == 15, i == 31});
      else passes++;
    end
    v4 = 1'b0; f4 = 1'b0;
    step();
  endtask

  // Word 0259 with three-cycle stalls after bits 2, 7 and 15
  task automatic test_gaps();
    logic [15:0] in_w;
    logic [15:0] exp_w;
    in_w  = 16'h0259;
    exp_w = 16'h358C;
    for (int i = 0; i < 16; i++) begin
      v4 = 1'b1; b4 = in_w[i]; f4 = (i == 0);
      step();
      checks++;
      if ({ov4, ob4, ol4, oe4} !== {1'b1, exp_w[i], i == 15, 1'b0})
        $display("[TB] FAIL gap_bit%0d got=%b want=%b", i, {ov4, ob4, ol4, oe4},
                 {1'b1, exp_w[i], i == 15, 1'b0});
      else passes++;
      if (i == 2 || i == 7 || i == 15) begin
        v4 = 1'b0; f4 = 1'b0; b4 = 1'b1;
        for (int g = 0; g < 3; g++) begin
          step();
          checks++;
          if ({ov4, ol4, oe4} !== 3'b000)
            $display("[TB] FAIL gap_idle%0d_%0d got=%b want=000", i, g, {ov4, ol4, oe4});
          else passes++;
        end
      end
    end
  endtask

  // Digit 1 = 1011 flags the word; the following clean word clears the flag
  task automatic test_invalid_digit();
    logic [31:0] in_w;
    logic [31:0] exp_w;
    in_w  = 32'h9876_00B0;
    exp_w = 32'hCBA9_33E3;
    for (int i = 0; i < 32; i++) begin
      v4 = 1'b1; b4 = in_w[i]; f4 = (i == 0);
      step();
      checks++;
      if ({ov4, ob4, ol4, oe4} !== {1'b1, exp_w[i], (i % 16) == 15, i == 15})
        $display("[TB] FAIL err_bit%0d got=%b want=%b", i, {ov4, ob4, ol4, oe4},
                 {1'b1, exp_w[i], (i % 16) == 15, i == 15});
      else passes++;
    end
    v4 = 1'b0; f4 = 1'b0;
    step();
  endtask

  // in_first at bit 6 aborts the partial word; 1234 then encodes to 4567
  task automatic test_abort();
    logic [15:0] old_w;
    logic [15:0] old_exp;
    logic [15:0] in_w;
    logic [15:0] exp_w;
    old_w   = 16'h0259;
    old_exp = 16'h358C;
    in_w    = 16'h1234;
    exp_w   = 16'h4567;
    for (int i = 0; i < 6; i++) begin
      v4 = 1'b1; b4 = old_w[i]; f4 = (i == 0);
      step();
      checks++;
      if ({ov4, ob4, ol4, oe4} !== {1'b1, old_exp[i], 2'b00})
        $display("[TB] FAIL abort_old%0d got=%b want=%b", i, {ov4, ob4, ol4, oe4},
                 {1'b1, old_exp[i], 2'b00});
      else passes++;
    end
    for (int i = 0; i < 16; i++) begin
      v4 = 1'b1; b4 = in_w[i]; f4 = (i == 0);
      step();
      checks++;
      if ({ov4, ob4, ol4, oe4} !== {1'b1, exp_w[i], i == 15, 1'b0})
        $display("[TB] FAIL abort_new%0d got=%b want=%b", i, {ov4, ob4, ol4, oe4},
                 {1'b1, exp_w[i], i == 15, 1'b0});
      else passes++;
    end
    v4 = 1'b0; f4 = 1'b0;
    step();
  endtask

  // Reset after bit 9, then a word without in_first starts from digit 0 bit 0
  task automatic test_mid_reset();
    logic [15:0] old_w;
    logic [15:0] old_exp;
    logic [15:0] in_w;
    logic [15:0] exp_w;
    old_w   = 16'h9876;
    old_exp = 16'hCBA9;
    in_w    = 16'h0259;
    exp_w   = 16'h358C;
    for (int i = 0; i < 10; i++) begin
      v4 = 1'b1; b4 = old_w[i]; f4 = (i == 0);
      step();
      checks++;
      if ({ov4, ob4, ol4, oe4} !== {1'b1, old_exp[i], 2'b00})
        $display("[TB] FAIL rst_old%0d got=%b want=%b", i, {ov4, ob4, ol4, oe4},
                 {1'b1, old_exp[i], 2'b00});
      else passes++;
    end
    rst = 1'b1; v4 = 1'b1; b4 = 1'b1; f4 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if ({ov4, ob4, ol4, oe4} !== 4'b0000)
        $display("[TB] FAIL rst_hold%0d got=%b want=0000", c, {ov4, ob4, ol4, oe4});
      else passes++;
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v4 = 1'b1; b4 = in_w[i]; f4 = 1'b0;
      step();
      checks++;
      if ({ov4, ob4, ol4, oe4} !== {1'b1, exp_w[i], i == 15, 1'b0})
        $display("[TB] FAIL rst_new%0d got=%b want=%b", i, {ov4, ob4, ol4, oe4},
                 {1'b1, exp_w[i], i == 15, 1'b0});
      else passes++;
    end
    v4 = 1'b0;
    step();
    checks++;
    if ({ov4, ol4, oe4} !== 3'b000)
      $display("[TB] FAIL rst_idle got=%b want=000", {ov4, ol4, oe4});
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    v1 = 1'b0; b1 = 1'b0; f1 = 1'b0;
    v4 = 1'b0; b4 = 1'b0; f4 = 1'b0;
    test_reset();
    test_single_digit();
    test_back_to_back();
    test_gaps();
    test_invalid_digit();
    test_abort();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
